pc_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It drives the PC register's `PC_hold`, the IF/ID register's hold and flush controls, the ID/EX bubble insert, and the next-PC source select. It detects load-use hazards and branch operand hazards, which arise because branches resolve in ID. A stall counter sequences multi-cycle stalls, and the block flushes IF/ID on taken branches and jumps.

---
 rtl/pc_hazard_ctrl_pkg.sv | 43 ++++
 rtl/pc_hazard_ctrl_need.sv | 41 ++++
 rtl/pc_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / sequencing controller.
// Holds the FSM state encoding, next-PC select codes and stall-length constants.
// Helper functions keep register-match and max logic identical across files.
package pc_hazard_ctrl_pkg;

    // Controller states: normal issue, or holding for the tail of a multi-cycle stall
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Next-PC source select codes
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // Stall lengths in cycles for each hazard class
    localparam logic [1:0] LU_STALL     = 2'd1;
    localparam logic [1:0] BR_LD_STALL  = 2'd2;
    localparam logic [1:0] BR_ALU_STALL = 2'd1;

    // A downstream destination conflicts with the ID instruction when it is not
    // $0 and equals a source register the ID instruction actually reads.
    function automatic logic reg_match(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (dest != 5'd0) &&
               ((uses_rs && (dest == rs)) || (uses_rt && (dest == rt)));
    endfunction

    // Larger of two stall lengths
    function automatic logic [1:0] max2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pc_hazard_ctrl_need.sv
// Combinational stall-need computation: how many stall cycles ID must wait (0..2).
// Latency: zero, purely combinational from register fields and control bits.
// No flow control; the parent decides whether the result is acted upon.
module hazard_need
    import pc_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    input  logic       is_branch_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_dest_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_dest_i,
    output logic [1:0] need_o
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(ex_dest_i,  rs_i, rt_i, uses_rs_i, uses_rt_i);
    assign mem_match = reg_match(mem_dest_i, rs_i, rt_i, uses_rs_i, uses_rt_i);

    // Take the longest stall demanded by any applicable hazard term.
    // Branches resolve in ID, so they must also wait for EX ALU results and
    // for loads still in MEM, which ordinary instructions get via forwarding.
    always_comb begin
        need_o = 2'd0;
        if (ex_mem_read_i && ex_match)
            need_o = max2(need_o, LU_STALL);
        if (is_branch_i && ex_mem_read_i && ex_match)
            need_o = max2(need_o, BR_LD_STALL);
        if (is_branch_i && ex_reg_write_i && !ex_mem_read_i && ex_match)
            need_o = max2(need_o, BR_ALU_STALL);
        if (is_branch_i && mem_mem_read_i && mem_match)
            need_o = max2(need_o, BR_ALU_STALL);
    end

endmodule

// File: rtl/pc_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID hold, IF-ID flush, ID-EX bubble, next-PC select.
// Latency: zero from hazard inputs to controls in RUN; a 2-cycle stall ends via the STALL state.
// A stall always overrides redirect; optional counters enabled by HAZARD_STATS_EN.
module pc_hazard_ctrl
    import pc_hazard_ctrl_pkg::*;
#(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_rs,
    input  logic [4:0]        IFID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_is_branch,
    input  logic              ID_branch_taken,
    input  logic              ID_jump,
    input  logic              IDEX_MemRead,
    input  logic              IDEX_RegWrite,
    input  logic [4:0]        IDEX_dest,
    input  logic              EXMEM_MemRead,
    input  logic [4:0]        EXMEM_dest,
    output logic              PC_hold,
    output logic              IFID_hold,
    output logic              IFID_flush,
    output logic              IDEX_bubble,
    output logic [1:0]        pc_src
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
`endif
);

    // Counter width must be usable even when statistics are compiled out
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("pc_hazard_ctrl: STAT_W must be at least 1");
    end

    state_e     state_q;
    logic [1:0] cnt_q;
    logic [1:0] need;

    hazard_need u_need (
        .rs_i           (IFID_rs),
        .rt_i           (IFID_rt),
        .uses_rs_i      (ID_uses_rs),
        .uses_rt_i      (ID_uses_rt),
        .is_branch_i    (ID_is_branch),
        .ex_mem_read_i  (IDEX_MemRead),
        .ex_reg_write_i (IDEX_RegWrite),
        .ex_dest_i      (IDEX_dest),
        .mem_mem_read_i (EXMEM_MemRead),
        .mem_dest_i     (EXMEM_dest),
        .need_o         (need)
    );

    // Sequencer: a need of 2 parks in STALL for the extra cycle; cnt holds the
    // cycles still owed after the current one. Reset aborts any stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        cnt_q   <= need - 2'd1;
                        state_q <= (need == BR_LD_STALL) ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (cnt_q <= 2'd1) begin
                        cnt_q   <= 2'd0;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q   <= cnt_q - 2'd1;
                    end
                end
                default: begin
                    cnt_q   <= 2'd0;
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Pipeline controls: stall beats redirect, jump beats branch, and a flush
    // is only ever produced in a cycle that does not hold IF/ID.
    always_comb begin
        PC_hold     = 1'b0;
        IFID_hold   = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        pc_src      = PCSRC_SEQ;
        if (!reset) begin
            if (state_q == ST_STALL || need != 2'd0) begin
                PC_hold     = 1'b1;
                IFID_hold   = 1'b1;
                IDEX_bubble = 1'b1;
            end else if (ID_jump) begin
                pc_src     = PCSRC_JMP;
                IFID_flush = 1'b1;
            end else if (ID_is_branch && ID_branch_taken) begin
                pc_src     = PCSRC_BR;
                IFID_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cycles_q;
    logic [STAT_W-1:0] flush_count_q;

    // Saturating event counters for stall cycles and redirect flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (PC_hold && (stall_cycles_q != {STAT_W{1'b1}}))
                stall_cycles_q <= stall_cycles_q + 1'b1;
            if (IFID_flush && (flush_count_q != {STAT_W{1'b1}}))
                flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Self-checking bench for pc_hazard_ctrl: directed scenarios plus random traffic.
// Expected controls come from a cycle-level model that tracks stall cycles still owed.
// Statistics outputs are checked only when HAZARD_STATS_EN is defined.
module tb_pc_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFID_rs, IFID_rt, IDEX_dest, EXMEM_dest;
    logic       ID_uses_rs, ID_uses_rt, ID_is_branch, ID_branch_taken, ID_jump;
    logic       IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
    logic       PC_hold, IFID_hold, IFID_flush, IDEX_bubble;
    logic [1:0] pc_src;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pc_hazard_ctrl #(.STAT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .IFID_rs         (IFID_rs),
        .IFID_rt         (IFID_rt),
        .ID_uses_rs      (ID_uses_rs),
        .ID_uses_rt      (ID_uses_rt),
        .ID_is_branch    (ID_is_branch),
        .ID_branch_taken (ID_branch_taken),
        .ID_jump         (ID_jump),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_RegWrite   (IDEX_RegWrite),
        .IDEX_dest       (IDEX_dest),
        .EXMEM_MemRead   (EXMEM_MemRead),
        .EXMEM_dest      (EXMEM_dest),
        .PC_hold         (PC_hold),
        .IFID_hold       (IFID_hold),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .pc_src          (pc_src)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: stall cycles still owed after the current cycle, and event tallies
    int m_owed = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hits(input logic [4:0] d);
        return d != 0 && ((ID_uses_rs && d == IFID_rs) || (ID_uses_rt && d == IFID_rt));
    endfunction

    // Required stall length straight from the hazard rules
    function automatic int ref_need();
        int n = 0;
        if (IDEX_MemRead && hits(IDEX_dest)) n = (ID_is_branch ? 2 : 1);
        if (ID_is_branch && IDEX_RegWrite && !IDEX_MemRead && hits(IDEX_dest) && n < 1) n = 1;
        if (ID_is_branch && EXMEM_MemRead && hits(EXMEM_dest) && n < 1) n = 1;
        return n;
    endfunction

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input bit br, input bit tk, input bit j,
                          input bit exmr, input bit exrw, input int exd,
                          input bit memmr, input int memd);
        IFID_rs = 5'(rs);  IFID_rt = 5'(rt);
        ID_uses_rs = urs;  ID_uses_rt = urt;
        ID_is_branch = br; ID_branch_taken = tk; ID_jump = j;
        IDEX_MemRead = exmr; IDEX_RegWrite = exrw; IDEX_dest = 5'(exd);
        EXMEM_MemRead = memmr; EXMEM_dest = 5'(memd);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle: check combinational controls against the model, then advance both.
    // Called with inputs applied at the falling edge; returns at the next falling edge.
    task automatic step();
        int n;
        bit e_hold, e_flush;
        logic [1:0] e_src;
        e_hold = 0; e_flush = 0; e_src = 2'b00; n = 0;
        if (!reset) begin
            n = ref_need();
            if (m_owed > 0 || n > 0) e_hold = 1;
            else if (ID_jump) begin e_flush = 1; e_src = 2'b10; end
            else if (ID_is_branch && ID_branch_taken) begin e_flush = 1; e_src = 2'b01; end
        end
        #1;
        check("PC_hold",     PC_hold,     e_hold);
        check("IFID_hold",   IFID_hold,   e_hold);
        check("IDEX_bubble", IDEX_bubble, e_hold);
        check("IFID_flush",  IFID_flush,  e_flush);
        check("pc_src",      pc_src,      e_src);
`ifdef HAZARD_STATS_EN
        check("stall_cycles", stall_cycles, m_stalls);
        check("flush_count",  flush_count,  m_flushes);
`endif
        @(posedge clk);
        if (reset) begin
            m_owed = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (m_owed > 0) m_owed--;
            else if (n > 0) m_owed = n - 1;
            if (e_hold) m_stalls++;
            if (e_flush) m_flushes++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();

        // Load-use: lw $2 in EX, add reading rs=2 in ID
        set_in(2, 7, 1, 1, 0, 0, 0, 1, 1, 2, 0, 0); step();
        idle(); step();

        // Branch on load in EX: beq rt=5, lw $5 in EX, held through the stall
        set_in(1, 5, 1, 1, 1, 1, 0, 1, 1, 5, 0, 0); step(); step();
        idle(); step();

        // Branch on ALU result in EX, then branch on load in MEM
        set_in(3, 0, 1, 0, 1, 0, 0, 0, 1, 3, 0, 0); step();
        set_in(0, 4, 0, 1, 1, 1, 0, 0, 0, 0, 1, 4); step();
        idle(); step();

        // Taken branch with no hazard
        set_in(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0); step();
        idle(); step();

        // Jump while a load to $0 sits in EX
        set_in(0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0); step();
        idle(); step();

        // Reset asserted during the STALL cycle
        set_in(1, 5, 1, 1, 1, 0, 0, 1, 1, 5, 0, 0); step();
        reset = 1'b1; step();
        reset = 1'b0; idle(); step();
        step();

        // Fresh counters: three load-use stalls and two taken branches
        reset = 1'b1; idle(); step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(6, 0, 1, 0, 0, 0, 0, 1, 1, 6, 0, 0); step();
            idle(); step();
        end
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
            idle(); step();
        end
`ifdef HAZARD_STATS_EN
        check("stall_cycles_total", stall_cycles, 32'd3);
        check("flush_count_total",  flush_count,  32'd2);
`endif

        // Random traffic over a small register set so hazards are frequent
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 5) == 0),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
